// File: rtl/dmem_port_arbiter.sv
// Purpose : two-port (core C high priority, debug D low priority) arbiter in
//           front of a single-port data memory, with starvation protection for D
//           and in-order read-response routing.
// Latency : grant is combinational in the request cycle; read data returns
//           MEM_LAT cycles after the accepting edge on the issuing port only.
// Backpr. : mem_ready_i = 0 blocks all grants; a requester holds its request
//           stable until it sees its gnt.
//
// Ports:
//   clk_i, rstn_i                     clock, asynchronous active-low reset
//   c_* / d_* (req, we, addr, wdata, be) request side of core / debug port
//   c_gnt_o / d_gnt_o                 request accepted this cycle
//   c_rvalid_o, c_rdata_o             read response to the core port
//   d_rvalid_o, d_rdata_o             read response to the debug port
//   mem_req_o .. mem_be_o             access towards the memory
//   mem_ready_i, mem_rdata_i          memory accept strobe and read data

module dmem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MEM_LAT  = 1,   // fixed memory read latency, 1..4
  parameter int MAX_WAIT = 8    // refusals of a pending D request before forcing it, 2..255
) (
  input  logic              clk_i,
  input  logic              rstn_i,

  // core load/store port
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [XLEN-1:0]   c_addr_i,
  input  logic [XLEN-1:0]   c_wdata_i,
  input  logic [XLEN/8-1:0] c_be_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [XLEN-1:0]   c_rdata_o,

  // debug inspection port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  input  logic [XLEN/8-1:0] d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,

  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_ready_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_D = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_wait;
  logic [7:0]         w_wait_nxt;

  // response pipeline: one slot per cycle of memory latency
  logic [MEM_LAT-1:0] r_pipe_vld;
  logic [MEM_LAT-1:0] r_pipe_own;   // 0 = core, 1 = debug

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic               w_c_gnt;
  logic               w_d_gnt;
  logic               w_any_gnt;
  logic               w_rd_push;
  logic               w_d_refused;
  logic               w_tail_vld;
  logic               w_tail_own;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        // Only switch on a cycle where the memory could have taken D; with
        // mem_ready_i low the state is frozen even if the counter saturates,
        // and the switch then happens on the next ready cycle that refuses D.
        if (mem_ready_i && w_d_refused && (w_wait_nxt == LP_MAX_WAIT)) begin
          w_state_nxt = ST_FORCE_D;
        end
      end
      ST_FORCE_D: begin
        // Leave once D got through, or if D withdrew its request.
        if (!d_req_i || w_d_gnt) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: grant outputs
  // ---------------------------------------------------------------------------
  // The reset term keeps the combinational grants low while reset is held,
  // so no access can leak to the memory before the block is out of reset.
  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (rstn_i && mem_ready_i) begin
      case (r_state)
        ST_NORMAL: begin
          if (c_req_i) begin
            w_c_gnt = 1'b1;
          end else if (d_req_i) begin
            w_d_gnt = 1'b1;
          end
        end
        ST_FORCE_D: begin
          // core is refused for the whole forced cycle
          w_d_gnt = d_req_i;
        end
        default: begin
          w_c_gnt = 1'b0;
          w_d_gnt = 1'b0;
        end
      endcase
    end
  end

  assign c_gnt_o     = w_c_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign w_any_gnt   = w_c_gnt | w_d_gnt;
  assign w_d_refused = d_req_i & ~w_d_gnt;

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  // Counts every cycle a D request waits, including cycles where the memory
  // is not ready, and saturates at MAX_WAIT.
  always_comb begin
    w_wait_nxt = r_wait;
    if (!w_d_refused) begin
      w_wait_nxt = 8'd0;
    end else if (r_wait < LP_MAX_WAIT) begin
      w_wait_nxt = r_wait + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wait <= 8'd0;
    end else begin
      r_wait <= w_wait_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------------------
  // Fields are forced to zero when nothing is granted so the memory bus is
  // quiet on idle cycles.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_c_gnt) begin
      mem_we_o    = c_we_i;
      mem_addr_o  = c_addr_i;
      mem_wdata_o = c_wdata_i;
      mem_be_o    = c_be_i;
    end else if (w_d_gnt) begin
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end
  end

  assign mem_req_o = w_any_gnt;

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  // Every accepted access pushes a slot; writes push an empty slot so that the
  // pipeline position always equals the age of the access. The owner bit of a
  // slot is only meaningful when its valid bit is set.
  assign w_rd_push = w_any_gnt & ~mem_we_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_push;
      r_pipe_own[0] <= w_d_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_own[i] <= r_pipe_own[i-1];
      end
    end
  end

  // The tail slot lines up with the cycle in which the memory presents data.
  assign w_tail_vld = r_pipe_vld[MEM_LAT-1];
  assign w_tail_own = r_pipe_own[MEM_LAT-1];

  assign c_rvalid_o = w_tail_vld & ~w_tail_own;
  assign d_rvalid_o = w_tail_vld &  w_tail_own;
  assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        c_req_i, c_we_i, d_req_i, d_we_i;
  logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
  logic [3:0]  c_be_i, d_be_i;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  // outputs of the MEM_LAT=1 instance
  logic        c_gnt1, d_gnt1, c_rv1, d_rv1, mreq1, mwe1;
  logic [31:0] c_rd1, d_rd1, maddr1, mwdata1;
  logic [3:0]  mbe1;
  // outputs of the MEM_LAT=3 instance
  logic        c_gnt3, d_gnt3, c_rv3, d_rv3, mreq3, mwe3;
  logic [31:0] c_rd3, d_rd3, maddr3, mwdata3;
  logic [3:0]  mbe3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  dmem_port_arbiter #(.XLEN(32), .MEM_LAT(1), .MAX_WAIT(8)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i), .c_be_i(c_be_i),
    .c_gnt_o(c_gnt1), .c_rvalid_o(c_rv1), .c_rdata_o(c_rd1),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_gnt_o(d_gnt1), .d_rvalid_o(d_rv1), .d_rdata_o(d_rd1),
    .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_wdata_o(mwdata1), .mem_be_o(mbe1),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  dmem_port_arbiter #(.XLEN(32), .MEM_LAT(3), .MAX_WAIT(8)) dut3 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i), .c_be_i(c_be_i),
    .c_gnt_o(c_gnt3), .c_rvalid_o(c_rv3), .c_rdata_o(c_rd3),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_gnt_o(d_gnt3), .d_rvalid_o(d_rv3), .d_rdata_o(d_rd3),
    .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_wdata_o(mwdata3), .mem_be_o(mbe3),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    string       name;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        ready;
    logic [31:0] rdata;
    logic        e_c_gnt, e_d_gnt, e_c_rv, e_d_rv;
    logic [31:0] e_c_rd, e_d_rd;
    logic        e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic [3:0]  e_mbe;
  } vec_t;

  vec_t vq[$];

  // idle row: no requests, memory ready, every output expected low
  function automatic vec_t nv(string name, logic [31:0] rdata);
    vec_t v;
    v.name = name;
    v.c_req = 0; v.c_we = 0; v.c_addr = 0; v.c_wdata = 0; v.c_be = 0;
    v.d_req = 0; v.d_we = 0; v.d_addr = 0; v.d_wdata = 0; v.d_be = 0;
    v.ready = 1; v.rdata = rdata;
    v.e_c_gnt = 0; v.e_d_gnt = 0; v.e_c_rv = 0; v.e_d_rv = 0;
    v.e_c_rd = 0; v.e_d_rd = 0;
    v.e_mreq = 0; v.e_mwe = 0; v.e_maddr = 0; v.e_mwdata = 0; v.e_mbe = 0;
    return v;
  endfunction

  function automatic vec_t c_in(vec_t vi, logic we, logic [31:0] a, logic [31:0] w, logic [3:0] be);
    vec_t v = vi;
    v.c_req = 1; v.c_we = we; v.c_addr = a; v.c_wdata = w; v.c_be = be;
    return v;
  endfunction

  function automatic vec_t d_in(vec_t vi, logic we, logic [31:0] a, logic [31:0] w, logic [3:0] be);
    vec_t v = vi;
    v.d_req = 1; v.d_we = we; v.d_addr = a; v.d_wdata = w; v.d_be = be;
    return v;
  endfunction

  // expected memory-side access for a grant in this row
  function automatic vec_t m_exp(vec_t vi, logic we, logic [31:0] a, logic [31:0] w, logic [3:0] be);
    vec_t v = vi;
    v.e_mreq = 1; v.e_mwe = we; v.e_maddr = a; v.e_mwdata = w; v.e_mbe = be;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [31:0] ca, input logic dr,
                       input logic [31:0] da, input logic rdy, input logic [31:0] rd);
    c_req_i = cr; c_we_i = 0; c_addr_i = ca; c_wdata_i = 0; c_be_i = cr ? 4'hF : 4'h0;
    d_req_i = dr; d_we_i = 0; d_addr_i = da; d_wdata_i = 0; d_be_i = dr ? 4'hF : 4'h0;
    mem_ready_i = rdy; mem_rdata_i = rd;
  endtask

  // drive one row, compare the MEM_LAT=1 instance mid-cycle, advance
  task automatic apply(input vec_t v);
    c_req_i = v.c_req; c_we_i = v.c_we; c_addr_i = v.c_addr; c_wdata_i = v.c_wdata; c_be_i = v.c_be;
    d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata; d_be_i = v.d_be;
    mem_ready_i = v.ready; mem_rdata_i = v.rdata;
    @(negedge clk_i);
    chk({v.name, ".c_gnt"},     {31'd0, c_gnt1}, {31'd0, v.e_c_gnt});
    chk({v.name, ".d_gnt"},     {31'd0, d_gnt1}, {31'd0, v.e_d_gnt});
    chk({v.name, ".c_rvalid"},  {31'd0, c_rv1},  {31'd0, v.e_c_rv});
    chk({v.name, ".d_rvalid"},  {31'd0, d_rv1},  {31'd0, v.e_d_rv});
    chk({v.name, ".c_rdata"},   c_rd1,           v.e_c_rd);
    chk({v.name, ".d_rdata"},   d_rd1,           v.e_d_rd);
    chk({v.name, ".mem_req"},   {31'd0, mreq1},  {31'd0, v.e_mreq});
    chk({v.name, ".mem_we"},    {31'd0, mwe1},   {31'd0, v.e_mwe});
    chk({v.name, ".mem_addr"},  maddr1,          v.e_maddr);
    chk({v.name, ".mem_wdata"}, mwdata1,         v.e_mwdata);
    chk({v.name, ".mem_be"},    {28'd0, mbe1},   {28'd0, v.e_mbe});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // ---------------- reset state, with requests asserted during reset
    rstn_i = 0;
    drive(1, 32'h99, 1, 32'h98, 1, 32'h5555_5555);
    #12;
    chk("rst.c_gnt1",    {31'd0, c_gnt1}, 0);
    chk("rst.d_gnt1",    {31'd0, d_gnt1}, 0);
    chk("rst.mem_req1",  {31'd0, mreq1},  0);
    chk("rst.mem_addr1", maddr1,          0);
    chk("rst.c_rvalid1", {31'd0, c_rv1},  0);
    chk("rst.d_rvalid1", {31'd0, d_rv1},  0);
    chk("rst.c_rdata1",  c_rd1,           0);
    chk("rst.c_gnt3",    {31'd0, c_gnt3}, 0);
    chk("rst.mem_req3",  {31'd0, mreq3},  0);
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk_i);
    rstn_i = 1;
    @(posedge clk_i);
    #1;

    // ---------------- table of single-cycle vectors (MEM_LAT=1)
    vq.push_back(nv("idle", 0));
    v = m_exp(c_in(nv("c_rd10", 0), 0, 32'h10, 0, 4'hF), 0, 32'h10, 0, 4'hF);
    v.e_c_gnt = 1; vq.push_back(v);
    v = nv("c_resp", 32'hDEAD_BEEF);
    v.e_c_rv = 1; v.e_c_rd = 32'hDEAD_BEEF; vq.push_back(v);
    v = m_exp(d_in(c_in(nv("cd_both", 32'h1111_1111), 0, 32'h30, 0, 4'hF), 0, 32'h40, 0, 4'hF), 0, 32'h30, 0, 4'hF);
    v.e_c_gnt = 1; vq.push_back(v);
    v = m_exp(d_in(nv("d_after_c", 32'hAAAA_0001), 0, 32'h40, 0, 4'hF), 0, 32'h40, 0, 4'hF);
    v.e_d_gnt = 1; v.e_c_rv = 1; v.e_c_rd = 32'hAAAA_0001; vq.push_back(v);
    v = nv("d_resp", 32'hBBBB_0002);
    v.e_d_rv = 1; v.e_d_rd = 32'hBBBB_0002; vq.push_back(v);
    v = m_exp(c_in(nv("c_wr20", 0), 1, 32'h20, 32'h1234_5678, 4'hF), 1, 32'h20, 32'h1234_5678, 4'hF);
    v.e_c_gnt = 1; vq.push_back(v);
    v = m_exp(d_in(nv("d_rd20", 32'hFFFF_FFFF), 0, 32'h20, 0, 4'hF), 0, 32'h20, 0, 4'hF);
    v.e_d_gnt = 1; vq.push_back(v);
    v = nv("d_resp20", 32'h1234_5678);
    v.e_d_rv = 1; v.e_d_rd = 32'h1234_5678; vq.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = c_in(nv("notready", 32'h7777_7777), 0, 32'h50, 0, 4'hF);
      v.ready = 0; vq.push_back(v);
    end
    v = m_exp(c_in(nv("ready_again", 0), 0, 32'h50, 0, 4'hF), 0, 32'h50, 0, 4'hF);
    v.e_c_gnt = 1; vq.push_back(v);
    v = nv("c_resp50", 32'hCAFE_0050);
    v.e_c_rv = 1; v.e_c_rd = 32'hCAFE_0050; vq.push_back(v);
    v = m_exp(c_in(nv("b2b_0", 0), 0, 32'h60, 0, 4'hF), 0, 32'h60, 0, 4'hF);
    v.e_c_gnt = 1; vq.push_back(v);
    v = m_exp(c_in(nv("b2b_1", 32'h0000_0060), 0, 32'h64, 0, 4'hF), 0, 32'h64, 0, 4'hF);
    v.e_c_gnt = 1; v.e_c_rv = 1; v.e_c_rd = 32'h0000_0060; vq.push_back(v);
    v = m_exp(d_in(nv("b2b_2", 32'h0000_0064), 0, 32'h68, 0, 4'hF), 0, 32'h68, 0, 4'hF);
    v.e_d_gnt = 1; v.e_c_rv = 1; v.e_c_rd = 32'h0000_0064; vq.push_back(v);
    v = nv("b2b_resp", 32'h0000_0068);
    v.e_d_rv = 1; v.e_d_rd = 32'h0000_0068; vq.push_back(v);
    v = m_exp(d_in(nv("d_wr70", 0), 1, 32'h70, 32'hA5A5_A5A5, 4'h3), 1, 32'h70, 32'hA5A5_A5A5, 4'h3);
    v.e_d_gnt = 1; vq.push_back(v);
    vq.push_back(nv("after_wr", 32'h9999_9999));

    foreach (vq[i]) apply(vq[i]);

    // ---------------- starvation: both ports request continuously
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'h100, 1, 32'h200, 1, 32'h0BAD_0000);
      @(negedge clk_i);
      chk($sformatf("starve%0d.c_gnt", i), {31'd0, c_gnt1}, {31'd0, i != 9});
      chk($sformatf("starve%0d.d_gnt", i), {31'd0, d_gnt1}, {31'd0, i == 9});
      if (i == 10) begin
        chk("starve10.d_rvalid", {31'd0, d_rv1}, 1);
        chk("starve10.c_rvalid", {31'd0, c_rv1}, 0);
      end
      @(posedge clk_i);
      #1;
    end
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk_i);
    #1;

    // ---------------- wait counter keeps counting while memory is not ready
    for (int i = 1; i <= 9; i++) begin
      drive(1, 32'h300, 1, 32'h400, i > 4, 0);
      @(negedge clk_i);
      chk($sformatf("rdywait%0d.c_gnt", i),   {31'd0, c_gnt1}, {31'd0, (i >= 5) && (i <= 8)});
      chk($sformatf("rdywait%0d.d_gnt", i),   {31'd0, d_gnt1}, {31'd0, i == 9});
      chk($sformatf("rdywait%0d.mem_req", i), {31'd0, mreq1},  {31'd0, i >= 5});
      @(posedge clk_i);
      #1;
    end
    drive(0, 0, 0, 0, 1, 0);

    // ---------------- MEM_LAT=3: in-flight responses dropped by reset
    @(negedge clk_i);
    rstn_i = 0;
    @(negedge clk_i);
    rstn_i = 1;
    @(posedge clk_i);
    #1;
    drive(1, 32'h300, 0, 0, 1, 0);
    @(negedge clk_i);
    chk("lat3.t0.c_gnt", {31'd0, c_gnt3}, 1);
    @(posedge clk_i);
    #1;
    drive(0, 0, 1, 32'h304, 1, 0);
    @(negedge clk_i);
    chk("lat3.t1.d_gnt", {31'd0, d_gnt3}, 1);
    @(posedge clk_i);
    #1;
    drive(1, 32'h308, 0, 0, 1, 0);
    @(negedge clk_i);
    chk("lat3.t2.c_gnt",    {31'd0, c_gnt3}, 1);
    chk("lat3.t2.c_rvalid", {31'd0, c_rv3},  0);
    chk("lat3.t2.d_rvalid", {31'd0, d_rv3},  0);
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 1, 32'h3333_0000);
    @(negedge clk_i);
    chk("lat3.t3.c_rvalid", {31'd0, c_rv3}, 1);
    chk("lat3.t3.c_rdata",  c_rd3,          32'h3333_0000);
    chk("lat3.t3.d_rvalid", {31'd0, d_rv3}, 0);
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 1, 32'h4444_0000);
    chk("lat3.t4.d_rvalid", {31'd0, d_rv3}, 1);
    rstn_i = 0;
    #1;
    chk("lat3.rst.d_rvalid", {31'd0, d_rv3}, 0);
    chk("lat3.rst.c_rvalid", {31'd0, c_rv3}, 0);
    chk("lat3.rst.d_rdata",  d_rd3,          0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("lat3.post%0d.c_rvalid", i), {31'd0, c_rv3}, 0);
      chk($sformatf("lat3.post%0d.d_rvalid", i), {31'd0, d_rv3}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store unit (port C, high priority) and the debug/test memory-inspection port (port D, low priority, starvation-protected).
- Grants at most one request per cycle and forwards it to the memory.
- Tracks in-flight reads and routes each read response back to the requester that issued it.
- Sits between the core, the debug read port and the data memory instance.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- MEM_LAT, 1, fixed read latency of the memory in cycles (1..4).
- MAX_WAIT, 8, maximum consecutive cycles a pending D request may be refused before it is forced through (2..255).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- c_req_i / d_req_i  in  1  request valid (C = core, D = debug)
- c_we_i / d_we_i  in  1  1 = write, 0 = read
- c_addr_i / d_addr_i  in  XLEN  byte address
- c_wdata_i / d_wdata_i  in  XLEN  write data
- c_be_i / d_be_i  in  XLEN/8  byte enables
- c_gnt_o / d_gnt_o  out  1  request accepted this cycle
- c_rvalid_o / d_rvalid_o  out  1  read data valid
- c_rdata_o / d_rdata_o  out  XLEN  read data
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  XLEN  memory address
- mem_wdata_o  out  XLEN  memory write data
- mem_be_o  out  XLEN/8  memory byte enables
- mem_ready_i  in  1  memory can accept an access this cycle
- mem_rdata_i  in  XLEN  read data, valid MEM_LAT cycles after an accepted read

Behaviour:
- Reset (async, rstn_i=0): all *_gnt_o, *_rvalid_o and mem_req_o are 0; all data/address outputs are 0; wait counter = 0; FSM = NORMAL; in-flight pipeline cleared. Responses in flight at reset are dropped and never delivered.
- Handshake:
  - A requester holds req/we/addr/wdata/be stable until it sees gnt.
  - gnt is combinational in the same cycle; the transaction is accepted on the clock edge where req && gnt.
  - gnt is never asserted without req, and never while mem_ready_i = 0.
  - At most one gnt per cycle.
- mem_req_o = c_gnt_o | d_gnt_o. mem_* fields are muxed combinationally from the granted port; with no grant they are held at 0.
- FSM:
  - NORMAL: C wins whenever c_req_i = 1; D is granted only when c_req_i = 0.
  - Wait counter: increments on each cycle with d_req_i = 1 && d_gnt_o = 0 (saturating at MAX_WAIT). Resets to 0 on a D grant or when d_req_i = 0.
  - NORMAL -> FORCE_D on the edge where the counter reaches MAX_WAIT.
  - FORCE_D: D is granted on the next cycle with mem_ready_i = 1, and C is refused that cycle. After the D grant: counter = 0, return to NORMAL.
  - If d_req_i drops while in FORCE_D (protocol violation), return to NORMAL.
- Response routing:
  - A MEM_LAT-deep shift register carries {valid, owner} for each accepted read. Writes push valid = 0.
  - At the tail, valid with owner = C drives c_rvalid_o = 1 and c_rdata_o = mem_rdata_i; owner = D drives d_rvalid_o likewise.
  - *_rvalid_o is high for exactly one cycle per accepted read. Responses return in issue order.
  - *_rdata_o is 0 when the matching rvalid is 0.
- Simultaneous events:
  - A new grant and a response delivery in the same cycle are independent and both occur.
  - Back-to-back reads reach full throughput (one per cycle).
- mem_ready_i = 0: no grants that cycle. The wait counter still increments for a pending D request. FSM state is held.

Test Plan:
- Reset, then C read 0x10, MEM_LAT=1, mem_rdata_i=0xDEADBEEF -> c_gnt_o=1 in the request cycle; c_rvalid_o=1 with c_rdata_o=0xDEADBEEF exactly one cycle later; d_rvalid_o stays 0.
- C and D read requests in the same cycle -> c_gnt_o=1, d_gnt_o=0. D is granted on the first cycle C deasserts; its data arrives on d_rdata_o only.
- C requests continuously, D requests continuously, MAX_WAIT=8 -> D is refused 8 cycles, forced grant on cycle 9 (C refused that cycle), then C wins again.
- C write 0x20 data 0x12345678 be=0xF, then D read 0x20 -> mem_we_o=1 with correct fields. No rvalid for the write. D read returns the memory's value on d_rvalid_o.
- mem_ready_i held 0 for 3 cycles with C pending -> no gnt, mem_req_o=0. Grant on the first ready cycle.
- MEM_LAT=3: issue C, D, C reads back-to-back, then assert rstn_i=0 after 2 cycles -> all rvalids drop immediately and no stale responses appear after reset release.
